pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Central pipeline controller for the five-stage core (IF, ID, EX, MEM, WB).
- Replaces the free-running phase counter and the always-enabled pipeline registers.
- Tracks per-stage valid bits and a destination-register scoreboard, and produces stage enables, bubbles, flushes and EX-stage forwarding selects.
- Handles load-use interlocks, branch/jump redirect and variable-latency MMIO/data-memory waits, and keeps saturating performance counters.

## Interface
Parameters:
- REG_W, 5: register-index width.
- FWD_EN, 1: 1 = forwarding with load-use interlock only; 0 = full interlock, no forwarding.
- CNT_W, 32: performance-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_ready  in  1  instruction memory has a valid word for the current PC.
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_W  destination of the ID instruction.
- id_rd_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_mem_req  in  1  ID instruction accesses memory/MMIO.
- ex_redirect  in  1  EX instruction resolved taken (branch taken, JAL, JALR).
- mem_ack  in  1  memory/MMIO access in MEM completes this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables.
- pc_redirect  out  1  PC loads the EX target instead of PC+4.
- stage_valid  out  4  valid bits of IF/ID, ID/EX, EX/MEM, MEM/WB.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 0 = RF, 1 = EX/MEM result, 2 = MEM/WB result.
- retire  out  1  valid instruction in WB this cycle.
- stall_cnt, flush_cnt, retire_cnt  out  CNT_W  saturating counters.

## Operation
- Scoreboard entries for ID/EX, EX/MEM and MEM/WB each hold: valid, rd, rd_wen, is_load, mem_req, rs1, rs2, rs1_used, rs2_used. Each entry moves forward only when the downstream enable is high.
- RAW match: rs_used, source equals rd, rd_wen, entry valid, and rd != 0. x0 never matches.
- Conditions are evaluated every cycle, highest priority first:
  1. MEM wait: EX/MEM valid, mem_req and !mem_ack.
     - pc_en, if_id_en, id_ex_en and ex_mem_en are all 0.
     - mem_wb_en = 1, and MEM/WB loads a bubble (valid 0).
     - A redirect or hazard pending in this cycle is ignored; it re-evaluates next cycle because upstream state is frozen.
  2. Redirect: ID/EX valid and ex_redirect.
     - pc_en = 1 and pc_redirect = 1.
     - IF/ID and ID/EX load bubbles; flush_cnt += 1.
     - Any load-use hazard in ID is discarded.
  3. Data hazard, ID versus scoreboard:
     - FWD_EN=1: a RAW match against an ID/EX entry with is_load.
     - FWD_EN=0: a RAW match against ID/EX, EX/MEM or MEM/WB.
     - Response: pc_en = 0, if_id_en = 0, ID/EX loads a bubble, EX/MEM and MEM/WB advance.
  4. if_ready low: pc_en = 0, IF/ID loads a bubble, downstream stages advance.
- stall_cnt increments on every cycle in which pc_en = 0 for reasons 1, 3 or 4.
- retire = MEM/WB valid; retire_cnt increments on it.
- Counters saturate at all-ones.
- Forwarding (FWD_EN=1 only):
  - Applies to the ID/EX entry's rs1/rs2.
  - EX/MEM match (non-load) selects 1; otherwise a MEM/WB match selects 2; otherwise 0.
  - EX/MEM takes priority over MEM/WB when both match.
- Forwarding with FWD_EN=0: selects are constant 0.

## Timing
- Enables, pc_redirect and the forwarding selects are combinational from the current state and inputs, and are valid in the same cycle.
- Valid bits and counters update on the rising edge.
- Redirect penalty: 2 bubbles.
- Load-use penalty: 1 bubble.
- MEM wait: N cycles of !mem_ack give N stall cycles and N WB bubbles.
- Reset values:
  - stage_valid = 0, all scoreboard entries invalid, counters 0, retire 0.
  - During reset the combinational outputs evaluate to: all enables 1, pc_redirect 0, forwarding selects 0.
  - The first valid IF/ID load happens on the first edge after rst_n rises with if_ready = 1.
- Reset assertion mid-stall clears all state immediately; no pending redirect survives.
- mem_ack asserted while EX/MEM is invalid is ignored.
- mem_ack in the same cycle as a request completes it with no stall.

## Structure
- Package pipe_ctrl_pkg holds:
  - fwd_sel_e (FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2);
  - the scoreboard entry struct sb_entry_t, parametrised by REG_W via a localparam;
  - stage index constants.
- Sub-module pipe_fwd_unit: purely combinational RAW comparator and forwarding-select logic, instantiated once. It is reused by the hazard check.

## Test plan
- Back-to-back ALU chain (addi x1,x0,5; add x2,x1,x1; add x3,x2,x1), FWD_EN=1:
  - no stalls;
  - fwd_a_sel = 1 on the second instruction;
  - on the third instruction, fwd_a_sel = 1 (x2) and fwd_b_sel = 2 (x1);
  - retire_cnt = 3.
- Load-use (lw x5,0(x0); add x6,x5,x0):
  - exactly 1 bubble, stall_cnt = 1;
  - add then has fwd_a_sel = 2.
- Taken branch in EX:
  - IF/ID and ID/EX valid = 0 on the next edge;
  - pc_redirect = 1 for one cycle;
  - flush_cnt = 1.
- MMIO store with mem_ack low for 3 cycles:
  - upstream frozen for 3 cycles, 3 WB bubbles, stall_cnt = 3;
  - a redirect presented during the wait takes effect only after the ack.
- FWD_EN=0 with the same ALU chain:
  - the second instruction stalls until x1's producer leaves WB (3 stall cycles);
  - selects stay 0.
- rst_n pulsed low mid-MEM-wait:
  - stage_valid = 0 and all counters 0 immediately;
  - all enables read 1 during reset;
  - the producer rd = x0 followed by a consumer of x0 produces no forwarding and no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline controller.
// Contents:
//   SB_REG_W     register-index width held in a scoreboard entry
//   STG_*        bit positions of each pipeline register in stage_valid
//   fwd_sel_e    EX operand source select
//   sb_entry_t   per-stage scoreboard entry
//   raw_hit()    read-after-write match of one source against one entry
package pipe_ctrl_pkg;

  // Scoreboard register-index width; the top-level REG_W must not exceed it.
  localparam int SB_REG_W = 5;

  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;
  localparam int NUM_STAGES = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic                rd_wen;
    logic                is_load;
    logic                mem_req;
    logic [SB_REG_W-1:0] rs1;
    logic [SB_REG_W-1:0] rs2;
    logic                rs1_used;
    logic                rs2_used;
  } sb_entry_t;

  // x0 is hard-wired to zero, so a write to it never produces a dependency.
  function automatic logic raw_hit(input logic used, input logic [SB_REG_W-1:0] rs,
                                   input sb_entry_t e);
    return used && e.valid && e.rd_wen && (rs == e.rd) && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational RAW comparator for the pipeline controller.
// Produces the ID-stage interlock request and the EX-stage operand selects.
// Ports:
//   id_entry            instruction currently in ID (valid = IF/ID valid)
//   id_ex/ex_mem/mem_wb scoreboard entries of the downstream registers
//   hazard              ID must be held and a bubble inserted into ID/EX
//   fwd_a_sel/b_sel     operand source for the instruction in ID/EX
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  sb_entry_t id_entry,
  input  sb_entry_t id_ex,
  input  sb_entry_t ex_mem,
  input  sb_entry_t mem_wb,
  output logic      hazard,
  output fwd_sel_e  fwd_a_sel,
  output fwd_sel_e  fwd_b_sel
);

  logic id_hit_ex, id_hit_mem, id_hit_wb;

  assign id_hit_ex  = raw_hit(id_entry.rs1_used, id_entry.rs1, id_ex)  ||
                      raw_hit(id_entry.rs2_used, id_entry.rs2, id_ex);
  assign id_hit_mem = raw_hit(id_entry.rs1_used, id_entry.rs1, ex_mem) ||
                      raw_hit(id_entry.rs2_used, id_entry.rs2, ex_mem);
  assign id_hit_wb  = raw_hit(id_entry.rs1_used, id_entry.rs1, mem_wb) ||
                      raw_hit(id_entry.rs2_used, id_entry.rs2, mem_wb);

  // A load in EX/MEM has no result yet; the load-use interlock guarantees the
  // consumer never reaches EX while that is the case, so it is simply skipped.
  function automatic fwd_sel_e pick(input logic used, input logic [SB_REG_W-1:0] rs,
                                    input sb_entry_t mem, input sb_entry_t wb);
    if (raw_hit(used, rs, mem) && !mem.is_load) return FWD_MEM;
    if (raw_hit(used, rs, wb)) return FWD_WB;
    return FWD_RF;
  endfunction

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign hazard    = id_entry.valid && id_hit_ex && id_ex.is_load;
      assign fwd_a_sel = id_ex.valid ? pick(id_ex.rs1_used, id_ex.rs1, ex_mem, mem_wb) : FWD_RF;
      assign fwd_b_sel = id_ex.valid ? pick(id_ex.rs2_used, id_ex.rs2, ex_mem, mem_wb) : FWD_RF;
    end else begin : g_interlock
      // Without bypass paths the consumer waits until the producer has left WB.
      assign hazard    = id_entry.valid && (id_hit_ex || id_hit_mem || id_hit_wb);
      assign fwd_a_sel = FWD_RF;
      assign fwd_b_sel = FWD_RF;
    end
  endgenerate

  logic unused_fields;
  assign unused_fields = ^{id_entry, id_ex, ex_mem, mem_wb, id_hit_mem, id_hit_wb};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central controller for the IF/ID/EX/MEM/WB pipeline.
// Tracks stage valid bits and a destination scoreboard and generates stage
// load enables, bubbles, flushes, PC redirect and EX forwarding selects.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_ready                         fetch word available for current PC
//   id_rs1/rs2, *_used, id_rd, ...   decode info of the instruction in ID
//   ex_redirect                      EX instruction resolved taken
//   mem_ack                          MEM access completes this cycle
//   pc_en ... mem_wb_en              pipeline register load enables
//   pc_redirect                      PC loads EX target
//   stage_valid                      {MEM/WB, EX/MEM, ID/EX, IF/ID} valid
//   fwd_a_sel, fwd_b_sel             0 = RF, 1 = EX/MEM, 2 = MEM/WB
//   retire                           valid instruction in WB
//   stall_cnt, flush_cnt, retire_cnt saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_ready,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_rd_wen,
  input  logic                  id_is_load,
  input  logic                  id_mem_req,
  input  logic                  ex_redirect,
  input  logic                  mem_ack,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  pc_redirect,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  retire,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic      ifid_valid;
  sb_entry_t id_entry, sb_id_ex, sb_ex_mem, sb_mem_wb;
  logic      hazard, mem_wait, redirect;
  logic      ifid_bubble, idex_bubble, memwb_bubble, stall, flush;
  fwd_sel_e  fwd_a, fwd_b;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = ifid_valid;
    id_entry.rd       = SB_REG_W'(id_rd);
    id_entry.rd_wen   = id_rd_wen;
    id_entry.is_load  = id_is_load;
    id_entry.mem_req  = id_mem_req;
    id_entry.rs1      = SB_REG_W'(id_rs1);
    id_entry.rs2      = SB_REG_W'(id_rs2);
    id_entry.rs1_used = id_rs1_used;
    id_entry.rs2_used = id_rs2_used;
  end

  pipe_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd (
    .id_entry (id_entry),
    .id_ex    (sb_id_ex),
    .ex_mem   (sb_ex_mem),
    .mem_wb   (sb_mem_wb),
    .hazard   (hazard),
    .fwd_a_sel(fwd_a),
    .fwd_b_sel(fwd_b)
  );

  assign mem_wait = sb_ex_mem.valid && sb_ex_mem.mem_req && !mem_ack;
  assign redirect = sb_id_ex.valid && ex_redirect;

  // Priority: memory wait freezes everything upstream, so a redirect or
  // interlock seen during the wait is simply re-evaluated once it clears.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    pc_redirect  = 1'b0;
    ifid_bubble  = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        memwb_bubble = 1'b1;
        stall        = 1'b1;
      end else if (redirect) begin
        pc_redirect = 1'b1;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
        flush       = 1'b1;
      end else if (hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        idex_bubble = 1'b1;
        stall       = 1'b1;
      end else if (!if_ready) begin
        pc_en       = 1'b0;
        ifid_bubble = 1'b1;
        stall       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid <= 1'b0;
      sb_id_ex   <= '0;
      sb_ex_mem  <= '0;
      sb_mem_wb  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (if_id_en)  ifid_valid <= !ifid_bubble;
      if (id_ex_en)  sb_id_ex   <= idex_bubble ? '0 : id_entry;
      if (ex_mem_en) sb_ex_mem  <= sb_id_ex;
      if (mem_wb_en) sb_mem_wb  <= memwb_bubble ? '0 : sb_ex_mem;
      if (stall && (stall_cnt != '1))        stall_cnt  <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))        flush_cnt  <= flush_cnt + CNT_W'(1);
      if (sb_mem_wb.valid && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign stage_valid[STG_IF_ID]  = ifid_valid;
  assign stage_valid[STG_ID_EX]  = sb_id_ex.valid;
  assign stage_valid[STG_EX_MEM] = sb_ex_mem.valid;
  assign stage_valid[STG_MEM_WB] = sb_mem_wb.valid;
  assign retire    = sb_mem_wb.valid;
  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Instance f uses forwarding with a
// 32-bit counter width; instance n is full-interlock with 3-bit counters so
// saturation is reachable. Between edges the id_* inputs always describe the
// instruction the bench expects to be sitting in IF/ID.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       if_ready = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_wen = 1'b0;
  logic       id_is_load = 1'b0, id_mem_req = 1'b0;
  logic       ex_redirect = 1'b0, mem_ack = 1'b1;

  logic        f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en, f_pc_redirect, f_retire;
  logic [3:0]  f_stage_valid;
  logic [1:0]  f_fwd_a_sel, f_fwd_b_sel;
  logic [31:0] f_stall_cnt, f_flush_cnt, f_retire_cnt;

  logic        n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en, n_pc_redirect, n_retire;
  logic [3:0]  n_stage_valid;
  logic [1:0]  n_fwd_a_sel, n_fwd_b_sel;
  logic [2:0]  n_stall_cnt, n_flush_cnt, n_retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .FWD_EN(1), .CNT_W(32)) dut_f (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_mem_req(id_mem_req),
    .ex_redirect(ex_redirect), .mem_ack(mem_ack),
    .pc_en(f_pc_en), .if_id_en(f_if_id_en), .id_ex_en(f_id_ex_en), .ex_mem_en(f_ex_mem_en),
    .mem_wb_en(f_mem_wb_en), .pc_redirect(f_pc_redirect), .stage_valid(f_stage_valid),
    .fwd_a_sel(f_fwd_a_sel), .fwd_b_sel(f_fwd_b_sel), .retire(f_retire),
    .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt), .retire_cnt(f_retire_cnt)
  );

  pipe_hazard_ctrl #(.REG_W(5), .FWD_EN(0), .CNT_W(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_mem_req(id_mem_req),
    .ex_redirect(ex_redirect), .mem_ack(mem_ack),
    .pc_en(n_pc_en), .if_id_en(n_if_id_en), .id_ex_en(n_id_ex_en), .ex_mem_en(n_ex_mem_en),
    .mem_wb_en(n_mem_wb_en), .pc_redirect(n_pc_redirect), .stage_valid(n_stage_valid),
    .fwd_a_sel(n_fwd_a_sel), .fwd_b_sel(n_fwd_b_sel), .retire(n_retire),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .retire_cnt(n_retire_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic mreq);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_mem_req = mreq;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ready = 1'b0; ex_redirect = 1'b0; mem_ack = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0; if_ready = 1'b0; ex_redirect = 1'b1; mem_ack = 1'b0;
    set_id(1, 1, 1, 1, 1, 1, 1, 1);
    #2;
    checks++;
    if ({f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_enables_f got %b want 11111",
               {f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en});
    end
    checks++;
    if ({f_pc_redirect, f_fwd_a_sel, f_fwd_b_sel} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_redirect_fwd got %b want 00000", {f_pc_redirect, f_fwd_a_sel, f_fwd_b_sel});
    end
    checks++;
    if ({f_stage_valid, f_retire} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_valid got %b want 00000", {f_stage_valid, f_retire});
    end
    checks++;
    if ({f_stall_cnt, f_flush_cnt, f_retire_cnt} !== 96'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", f_stall_cnt, f_flush_cnt, f_retire_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en, n_pc_redirect} !== 6'b111110) begin
      errors++;
      $display("FAIL reset_enables_n got %b want 111110",
               {n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en, n_pc_redirect});
    end
  endtask

  // addi x1,x0,5 ; add x2,x1,x1 ; add x3,x2,x1 ; then nops
  task automatic test_alu_chain();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 0, 1, 1, 0, 0); #1;
    checks++;
    if (f_stage_valid !== 4'b0001) begin
      errors++; $display("FAIL alu_first_fetch got %b want 0001", f_stage_valid);
    end
    tick(); set_id(1, 1, 1, 1, 2, 1, 0, 0); #1;
    checks++;
    if ({f_pc_en, f_if_id_en} !== 2'b11) begin
      errors++; $display("FAIL alu_no_stall got %b want 11", {f_pc_en, f_if_id_en});
    end
    tick(); set_id(2, 1, 1, 1, 3, 1, 0, 0); #1;
    checks++;
    if ({f_fwd_a_sel, f_fwd_b_sel} !== {2'd1, 2'd1}) begin
      errors++; $display("FAIL alu_fwd_second got a=%0d b=%0d want a=1 b=1", f_fwd_a_sel, f_fwd_b_sel);
    end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if ({f_fwd_a_sel, f_fwd_b_sel} !== {2'd1, 2'd2}) begin
      errors++; $display("FAIL alu_fwd_third got a=%0d b=%0d want a=1 b=2", f_fwd_a_sel, f_fwd_b_sel);
    end
    checks++;
    if (f_stage_valid !== 4'b1111) begin
      errors++; $display("FAIL alu_full_pipe got %b want 1111", f_stage_valid);
    end
    repeat (3) tick();
    checks++;
    if (f_retire_cnt !== 32'd3 || f_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL alu_counts got retire=%0d stall=%0d want 3 0", f_retire_cnt, f_stall_cnt);
    end
  endtask

  // lw x5,0(x0) ; add x6,x5,x0
  task automatic test_load_use();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 0, 5, 1, 1, 1);
    tick(); set_id(5, 1, 0, 1, 6, 1, 0, 0); #1;
    checks++;
    if ({f_pc_en, f_if_id_en, f_id_ex_en} !== 3'b001) begin
      errors++; $display("FAIL lu_interlock got %b want 001", {f_pc_en, f_if_id_en, f_id_ex_en});
    end
    tick();
    checks++;
    if (f_stage_valid !== 4'b0101 || f_stall_cnt !== 32'd1 || f_pc_en !== 1'b1) begin
      errors++; $display("FAIL lu_bubble got valid=%b stall=%0d pc_en=%b want 0101 1 1",
                         f_stage_valid, f_stall_cnt, f_pc_en);
    end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if ({f_fwd_a_sel, f_fwd_b_sel} !== {2'd2, 2'd0} || f_stage_valid !== 4'b1011) begin
      errors++; $display("FAIL lu_fwd got a=%0d b=%0d valid=%b want a=2 b=0 1011",
                         f_fwd_a_sel, f_fwd_b_sel, f_stage_valid);
    end
    tick();
    checks++;
    if (f_stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_stall_total got %0d want 1", f_stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 1, 0, 0, 0, 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 1'b1; #1;
    checks++;
    if ({f_pc_redirect, f_pc_en} !== 2'b11) begin
      errors++; $display("FAIL br_redirect got %b want 11", {f_pc_redirect, f_pc_en});
    end
    tick();
    checks++;
    if (f_stage_valid !== 4'b0100 || f_flush_cnt !== 32'd1) begin
      errors++; $display("FAIL br_flush got valid=%b flush=%0d want 0100 1", f_stage_valid, f_flush_cnt);
    end
    checks++;
    if (f_pc_redirect !== 1'b0) begin
      errors++; $display("FAIL br_one_cycle got %b want 0", f_pc_redirect);
    end
    ex_redirect = 1'b0;
  endtask

  // store with mem_ack low 3 cycles, branch behind it resolving during the wait
  task automatic test_mmio_wait();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 1, 0, 0, 0, 1);
    tick(); set_id(0, 1, 0, 1, 0, 0, 0, 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); mem_ack = 1'b0; ex_redirect = 1'b1; #1;
    checks++;
    if ({f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en, f_pc_redirect} !== 6'b000010) begin
      errors++; $display("FAIL mmio_freeze got %b want 000010",
                         {f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en, f_pc_redirect});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({f_stage_valid, f_retire} !== 5'b01110) begin
        errors++; $display("FAIL mmio_wb_bubble[%0d] got %b want 01110", i, {f_stage_valid, f_retire});
      end
    end
    checks++;
    if (f_stall_cnt !== 32'd3 || f_flush_cnt !== 32'd0 || f_retire_cnt !== 32'd0) begin
      errors++; $display("FAIL mmio_counts got stall=%0d flush=%0d retire=%0d want 3 0 0",
                         f_stall_cnt, f_flush_cnt, f_retire_cnt);
    end
    mem_ack = 1'b1; #1;
    checks++;
    if (f_pc_redirect !== 1'b1) begin
      errors++; $display("FAIL mmio_redirect_after_ack got %b want 1", f_pc_redirect);
    end
    tick(); ex_redirect = 1'b0;
    checks++;
    if (f_stage_valid !== 4'b1100 || f_flush_cnt !== 32'd1 || f_stall_cnt !== 32'd3) begin
      errors++; $display("FAIL mmio_post got valid=%b flush=%0d stall=%0d want 1100 1 3",
                         f_stage_valid, f_flush_cnt, f_stall_cnt);
    end
  endtask

  task automatic test_no_forwarding();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 0, 1, 1, 0, 0);
    tick(); set_id(1, 1, 1, 1, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({n_pc_en, n_if_id_en, n_fwd_a_sel, n_fwd_b_sel} !== 6'b000000) begin
        errors++; $display("FAIL nofwd_stall[%0d] got %b want 000000", i,
                           {n_pc_en, n_if_id_en, n_fwd_a_sel, n_fwd_b_sel});
      end
      tick();
    end
    #1;
    checks++;
    if (n_pc_en !== 1'b1 || n_stall_cnt !== 3'd3 || n_stage_valid !== 4'b0001) begin
      errors++; $display("FAIL nofwd_release got pc_en=%b stall=%0d valid=%b want 1 3 0001",
                         n_pc_en, n_stall_cnt, n_stage_valid);
    end
    if_ready = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick();
    checks++;
    if (n_stall_cnt !== 3'd7 || n_retire_cnt !== 3'd2) begin
      errors++; $display("FAIL nofwd_saturate got stall=%0d retire=%0d want 7 2", n_stall_cnt, n_retire_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); if_ready = 1'b1;
    tick(); set_id(0, 1, 0, 1, 0, 0, 0, 1);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); mem_ack = 1'b0;
    tick(); tick();
    checks++;
    if (f_stall_cnt !== 32'd2) begin
      errors++; $display("FAIL rmw_pre got stall=%0d want 2", f_stall_cnt);
    end
    #2;
    rst_n = 1'b0; if_ready = 1'b0;
    #1;
    checks++;
    if (f_stage_valid !== 4'b0000 || {f_stall_cnt, f_flush_cnt, f_retire_cnt} !== 96'd0) begin
      errors++; $display("FAIL rmw_clear got valid=%b stall=%0d flush=%0d retire=%0d want 0000 0 0 0",
                         f_stage_valid, f_stall_cnt, f_flush_cnt, f_retire_cnt);
    end
    checks++;
    if ({f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en, f_pc_redirect} !== 6'b111110) begin
      errors++; $display("FAIL rmw_enables got %b want 111110",
                         {f_pc_en, f_if_id_en, f_id_ex_en, f_ex_mem_en, f_mem_wb_en, f_pc_redirect});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; if_ready = 1'b1;
    tick(); set_id(0, 0, 0, 0, 0, 1, 1, 1);
    tick(); set_id(0, 1, 0, 1, 0, 1, 0, 0); #1;
    checks++;
    if ({f_pc_en, f_if_id_en} !== 2'b11) begin
      errors++; $display("FAIL x0_no_stall got %b want 11", {f_pc_en, f_if_id_en});
    end
    tick(); set_id(0, 1, 0, 1, 0, 0, 0, 0); #1;
    checks++;
    if ({f_fwd_a_sel, f_fwd_b_sel} !== 4'b0000) begin
      errors++; $display("FAIL x0_fwd_q got a=%0d b=%0d want 0 0", f_fwd_a_sel, f_fwd_b_sel);
    end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++;
    if ({f_fwd_a_sel, f_fwd_b_sel} !== 4'b0000 || f_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL x0_fwd_r got a=%0d b=%0d stall=%0d want 0 0 0",
                         f_fwd_a_sel, f_fwd_b_sel, f_stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch();
    test_mmio_wait();
    test_no_forwarding();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
